// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver, common anode.
// Latches BCD value, scans anodes, blanks leading zeros, blinks.
module seg7_scan_driver #(
   parameter int REFRESH_BITS = 17,
   parameter int BLINK_BITS   = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] digits_in,
   input  logic        load,
   input  logic        blank_lz,
   input  logic        blink_en,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        frame_done
);

   logic [15:0]             shadow_q, shadow_d;
   logic [REFRESH_BITS-1:0] dwell_q, dwell_d;
   logic [1:0]              idx_q, idx_d;
   logic [BLINK_BITS-1:0]   blink_q, blink_d;
   logic [6:0]              seg_q, seg_d;
   logic [3:0]              an_q, an_d;
   logic                    fd_q, fd_d;

   logic       wrap;
   logic [3:0] nib;
   logic       blanked;
   logic       gate;

   // Scan timing, shadow capture and blink phase
   always_comb begin
      wrap     = &dwell_q;
      dwell_d  = dwell_q + 1'b1;
      idx_d    = wrap ? idx_q + 2'd1 : idx_q;
      fd_d     = wrap && (idx_q == 2'd3);
      shadow_d = load ? digits_in : shadow_q;
      blink_d  = blink_q + 1'b1;
   end

   // Digit select, zero blanking and blink gate for the lit slot
   always_comb begin
      nib     = shadow_q[3:0];
      blanked = 1'b0;
      unique case (idx_q)
         2'd0: begin
            nib     = shadow_q[3:0];
            blanked = 1'b0;
         end
         2'd1: begin
            nib     = shadow_q[7:4];
            blanked = blank_lz && (shadow_q[15:4] == 12'h000);
         end
         2'd2: begin
            nib     = shadow_q[11:8];
            blanked = blank_lz && (shadow_q[15:8] == 8'h00);
         end
         2'd3: begin
            nib     = shadow_q[15:12];
            blanked = blank_lz && (shadow_q[15:12] == 4'h0);
         end
      endcase
      gate = blink_en && blink_q[BLINK_BITS-1];
      an_d = (blanked || gate) ? 4'b1111 : ~(4'b0001 << idx_q);
   end

   // Glyph lookup, segments active-low {g..a}
   always_comb begin
      seg_d = 7'b0111111;
      case (nib)
         4'd0:    seg_d = 7'b1000000;
         4'd1:    seg_d = 7'b1111001;
         4'd2:    seg_d = 7'b0100100;
         4'd3:    seg_d = 7'b0110000;
         4'd4:    seg_d = 7'b0011001;
         4'd5:    seg_d = 7'b0010010;
         4'd6:    seg_d = 7'b0000010;
         4'd7:    seg_d = 7'b1111000;
         4'd8:    seg_d = 7'b0000000;
         4'd9:    seg_d = 7'b0010000;
         default: seg_d = 7'b0111111;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_q <= '0;
         dwell_q  <= '0;
         idx_q    <= '0;
         blink_q  <= '0;
         seg_q    <= 7'b1111111;
         an_q     <= 4'b1111;
         fd_q     <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         dwell_q  <= dwell_d;
         idx_q    <= idx_d;
         blink_q  <= blink_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
         fd_q     <= fd_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with small refresh/blink counters.
// Cycle-count model feeds an expectation queue checked after each edge.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] digits_in;
   logic        load;
   logic        blank_lz;
   logic        blink_en;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_done;

   seg7_scan_driver #(.REFRESH_BITS(2), .BLINK_BITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load),
      .blank_lz(blank_lz), .blink_en(blink_en),
      .seg(seg), .an(an), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errs    = 0;
   int n       = 0;
   int fd_cnt  = 0;
   logic [15:0] shadow_m = 16'h0000;
   logic [11:0] sb_q[$];
   string tag = "init";

   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] t[16];
      t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
            7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
      return t[v];
   endfunction

   function automatic logic [11:0] expect_out(input int cnt,
                                             input logic [15:0] sh,
                                             input logic bl, input logic be,
                                             input int edge_no);
      int          d;
      logic        lead;
      logic [3:0]  dark;
      logic [3:0]  a;
      logic [3:0]  v;
      d    = (cnt >> 2) & 3;
      lead = 1'b1;
      dark = 4'b0000;
      for (int i = 3; i >= 1; i--) begin
         if (sh[i*4 +: 4] != 4'h0) lead = 1'b0;
         dark[i] = lead && bl;
      end
      v = sh[d*4 +: 4];
      a = 4'b1111;
      a[d] = 1'b0;
      if (dark[d] || (be && ((cnt >> 3) & 1) == 1)) a = 4'b1111;
      return {a, glyph(v), (edge_no % 16) == 0};
   endfunction

   task automatic tick();
      logic [11:0] e;
      logic [11:0] o;
      @(posedge clk);
      if (!rst_n) begin
         e = {4'b1111, 7'b1111111, 1'b0};
         n = 0;
         shadow_m = 16'h0000;
      end else begin
         e = expect_out(n, shadow_m, blank_lz, blink_en, n + 1);
         if (load) shadow_m = digits_in;
         n++;
      end
      sb_q.push_back(e);
      #1;
      e = sb_q.pop_front();
      o = {an, seg, frame_done};
      if (frame_done) fd_cnt++;
      vectors++;
      assert (o === e) else begin
         errs++;
         $error("FAIL %s: an/seg/fd got %b/%b/%b want %b/%b/%b", tag,
                o[11:8], o[7:1], o[0], e[11:8], e[7:1], e[0]);
      end
   endtask

   task automatic run(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic do_load(input logic [15:0] v);
      digits_in = v;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic check_const(input string t, input logic [31:0] o,
                              input logic [31:0] e);
      vectors++;
      assert (o === e) else begin
         errs++;
         $error("FAIL %s: got %0h want %0h", t, o, e);
      end
   endtask

   initial begin
      int guard;
      rst_n = 1'b0; digits_in = 16'h0; load = 1'b0;
      blank_lz = 1'b0; blink_en = 1'b0;
      #2;
      tag = "reset";
      run(2);
      rst_n = 1'b1;

      tag = "first";
      tick();
      check_const("first_an", 32'(an), 32'(4'b1110));
      check_const("first_seg", 32'(seg), 32'(7'b1000000));

      tag = "scan1234";
      do_load(16'h1234);
      fd_cnt = 0;
      run(32);
      check_const("fd_per_32", fd_cnt, 2);

      tag = "lz0040";
      blank_lz = 1'b1;
      do_load(16'h0040);
      run(20);
      tag = "lz0000";
      do_load(16'h0000);
      run(20);
      tag = "dash00A5";
      do_load(16'h00A5);
      run(20);

      tag = "blink8888";
      blank_lz = 1'b0;
      blink_en = 1'b1;
      do_load(16'h8888);
      fd_cnt = 0;
      run(48);
      check_const("fd_blink", fd_cnt, 3);
      blink_en = 1'b0;

      tag = "midreset";
      guard = 0;
      while (((n >> 2) & 3) != 2 && guard < 64) begin
         tick();
         guard++;
      end
      check_const("wait_digit2", guard < 64, 1);
      tick();
      check_const("digit2_lit", 32'(an), 32'(4'b1011));
      rst_n = 1'b0;
      tick();
      check_const("rst_an", 32'(an), 32'(4'b1111));
      check_const("rst_seg", 32'(seg), 32'(7'b1111111));
      rst_n = 1'b1;
      tag = "postreset";
      tick();
      check_const("restart_an", 32'(an), 32'(4'b1110));
      check_const("restart_seg", 32'(seg), 32'(7'b1000000));
      run(6);

      tag = "wrapload";
      guard = 0;
      while (((n + 1) % 16) != 0 && guard < 64) begin
         tick();
         guard++;
      end
      check_const("wait_wrap", guard < 64, 1);
      do_load(16'h5678);
      tick();
      check_const("wrap_an", 32'(an), 32'(4'b1110));
      check_const("wrap_seg", 32'(seg), 32'(7'b0000000));
      run(16);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
